crc3_frame_ctrl: RTL and testbench
==================================

CRC3_FRAME_CTRL -- requirements
Module: crc3_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 1..32).
REQ-002 SHALL have port GCLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port CLEAR_bar  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port START  input  1  frame-start request, sampled per REQ-012/REQ-018.
REQ-005 SHALL have port ABORT  input  1  synchronous frame abort.
REQ-006 SHALL have port LINK_IN  input  1  serial link bit, MSB first, shared with the CRC3 checker's serial input.
REQ-007 SHALL have port CHK_ERROR  input  1  checker remainder-nonzero flag.
REQ-008 SHALL have port RES_ACK  input  1  downstream accepts the current result.
REQ-009 SHALL have outputs CHK_CLR_bar 1, CHK_SELECT 1, BUSY 1, RES_VALID 1, RES_ERROR 1, DATA_OUT DATA_BITS, FRAME_CNT 8, ERR_CNT 8.
REQ-010 SHALL treat CHK_CLR_bar as the checker's clear (low = checker held at zero), and CHK_SELECT as the checker's pass-through select.

Function
REQ-011 SHALL implement FSM states IDLE, DATA, CRC, CHECK, RESULT, with a bit counter wide enough for DATA_BITS-1.
REQ-012 IDLE: START=1 at an edge -> DATA, bit counter=0, DATA_OUT unchanged until the first DATA edge.
REQ-013 DATA: each edge shifts DATA_OUT left, LINK_IN into bit 0; after DATA_BITS edges -> CRC, counter=0.
REQ-014 CRC: 3 edges, LINK_IN not captured; after the 3rd -> CHECK.
REQ-015 CHECK: one cycle; exit edge latches RES_ERROR<=CHK_ERROR, increments FRAME_CNT (mod 256), increments ERR_CNT if CHK_ERROR=1 (saturating at 255), -> RESULT.
REQ-016 RESULT: RES_VALID=1; DATA_OUT and RES_ERROR SHALL hold stable until RES_ACK=1 at an edge.
REQ-017 RESULT with RES_ACK=1, START=0 -> IDLE; RES_VALID drops after that edge.
REQ-018 RESULT with RES_ACK=1 and START=1 at the same edge -> DATA directly (back-to-back frame, no idle cycle).
REQ-019 START SHALL be ignored in DATA, CRC, CHECK and in RESULT without RES_ACK.
REQ-020 ABORT=1 at any edge SHALL force IDLE, with priority over START/RES_ACK; counters, DATA_OUT, RES_ERROR unchanged.
REQ-021 Outputs SHALL be state decodes: CHK_CLR_bar=1 only in DATA, CRC, CHECK; CHK_SELECT=1 only in DATA; BUSY=1 in DATA, CRC, CHECK; RES_VALID=1 only in RESULT.
REQ-022 Latency: START sampled at edge 0 -> data bits sampled edges 1..N, CRC bits edges N+1..N+3, RES_VALID high after edge N+4 (N=DATA_BITS).
REQ-023 CRC field is remainder of data·x^3 mod x^3+x+1, sent MSB first; a correct frame leaves CHK_ERROR=0 in CHECK.

Reset
REQ-024 CLEAR_bar=0 SHALL immediately, without a clock, force IDLE, counter=0, DATA_OUT=0, RES_ERROR=0, FRAME_CNT=0, ERR_CNT=0; hence CHK_CLR_bar=0, CHK_SELECT=0, BUSY=0, RES_VALID=0.
REQ-025 Reset mid-frame SHALL discard the frame with no counter update; the first START after release begins a fresh frame.

Verification (bench includes a behavioural CRC3 checker, x^3+x+1, cleared by CHK_CLR_bar)
REQ-026 START, LINK_IN=1010_0101 then 101 -> RES_VALID after edge 12, DATA_OUT=8'hA5, RES_ERROR=0, FRAME_CNT=1, ERR_CNT=0.
REQ-027 Same data, CRC 100 -> RES_ERROR=1, ERR_CNT=1; RES_ACK -> IDLE next edge.
REQ-028 RES_ACK+START same edge, second frame 8'h00/000 -> BUSY high next cycle, no IDLE cycle, DATA_OUT=8'h00, RES_ERROR=0, FRAME_CNT=2.
REQ-029 ABORT during CRC state -> IDLE next edge, CHK_CLR_bar=0, FRAME_CNT unchanged; START in RESULT without RES_ACK ignored.
REQ-030 CLEAR_bar pulsed low mid-DATA -> all outputs at reset values asynchronously; 256 error frames -> ERR_CNT=255, FRAME_CNT wraps to 0.

Source files
------------

// File: rtl/crc3_frame_ctrl.sv
// Serial frame receiver: DATA_BITS payload bits then a 3-bit CRC, checked
// by an external CRC3 checker; reports per-frame status and running counts.
module crc3_frame_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 GCLK,
    input  logic                 CLEAR_bar,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 LINK_IN,
    input  logic                 CHK_ERROR,
    input  logic                 RES_ACK,
    output logic                 CHK_CLR_bar,
    output logic                 CHK_SELECT,
    output logic                 BUSY,
    output logic                 RES_VALID,
    output logic                 RES_ERROR,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic [7:0]           FRAME_CNT,
    output logic [7:0]           ERR_CNT
);

    // Counter must reach DATA_BITS-1 and also 2 for the CRC phase.
    localparam int CW = (DATA_BITS > 4) ? $clog2(DATA_BITS) : 2;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CRC,
        CHECK,
        RESULT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          data_last;
    logic          crc_last;

    assign data_last = (cnt == CW'(DATA_BITS - 1));
    assign crc_last  = (cnt == CW'(2));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ABORT) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    if (data_last) begin
                        state_nxt = CRC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                CRC: begin
                    if (crc_last) begin
                        state_nxt = CHECK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                CHECK: begin
                    state_nxt = RESULT;
                end
                RESULT: begin
                    // Ack with START chains straight into the next frame.
                    if (RES_ACK) begin
                        state_nxt = START ? DATA : IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge GCLK or negedge CLEAR_bar) begin
        if (!CLEAR_bar) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge GCLK or negedge CLEAR_bar) begin
        if (!CLEAR_bar) begin
            DATA_OUT  <= '0;
            RES_ERROR <= 1'b0;
            FRAME_CNT <= 8'd0;
            ERR_CNT   <= 8'd0;
        end else if (!ABORT) begin
            if (state == DATA) begin
                DATA_OUT <= DATA_BITS'({DATA_OUT, LINK_IN});
            end
            if (state == CHECK) begin
                RES_ERROR <= CHK_ERROR;
                FRAME_CNT <= FRAME_CNT + 8'd1;
                if (CHK_ERROR && (ERR_CNT != 8'hFF)) begin
                    ERR_CNT <= ERR_CNT + 8'd1;
                end
            end
        end
    end

    assign CHK_CLR_bar = (state == DATA) || (state == CRC) || (state == CHECK);
    assign CHK_SELECT  = (state == DATA);
    assign BUSY        = CHK_CLR_bar;
    assign RES_VALID   = (state == RESULT);

endmodule

// File: tb/tb_crc3_frame_ctrl.sv
// Randomized scoreboard bench for crc3_frame_ctrl with a behavioural
// CRC3 checker (x^3+x+1) attached to the link.
module tb_crc3_frame_ctrl;

    logic       GCLK;
    logic       CLEAR_bar;
    logic       START;
    logic       ABORT;
    logic       LINK_IN;
    logic       CHK_ERROR;
    logic       RES_ACK;
    logic       CHK_CLR_bar;
    logic       CHK_SELECT;
    logic       BUSY;
    logic       RES_VALID;
    logic       RES_ERROR;
    logic [7:0] DATA_OUT;
    logic [7:0] FRAME_CNT;
    logic [7:0] ERR_CNT;

    crc3_frame_ctrl #(.DATA_BITS(8)) dut (
        .GCLK(GCLK),
        .CLEAR_bar(CLEAR_bar),
        .START(START),
        .ABORT(ABORT),
        .LINK_IN(LINK_IN),
        .CHK_ERROR(CHK_ERROR),
        .RES_ACK(RES_ACK),
        .CHK_CLR_bar(CHK_CLR_bar),
        .CHK_SELECT(CHK_SELECT),
        .BUSY(BUSY),
        .RES_VALID(RES_VALID),
        .RES_ERROR(RES_ERROR),
        .DATA_OUT(DATA_OUT),
        .FRAME_CNT(FRAME_CNT),
        .ERR_CNT(ERR_CNT)
    );

    initial begin
        GCLK = 1'b0;
        forever #5 GCLK = ~GCLK;
    end

    // Serial CRC3 checker: remainder of the received bit stream mod x^3+x+1.
    logic [2:0] chk_r;
    always @(posedge GCLK or negedge CHK_CLR_bar) begin
        if (!CHK_CLR_bar) chk_r <= 3'b000;
        else chk_r <= {chk_r[1:0], LINK_IN} ^ (chk_r[2] ? 3'b011 : 3'b000);
    end
    assign CHK_ERROR = |chk_r;

    typedef struct {
        logic [7:0] d;
        logic       e;
        logic [7:0] fc;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;
    int   exp_errs = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC: polynomial long division of d*x^3 by x^3+x+1.
    function automatic logic [2:0] crc3(input logic [7:0] d);
        logic [10:0] v;
        v = {d, 3'b000};
        for (int i = 10; i >= 3; i--)
            if (v[i]) v[i-:4] = v[i-:4] ^ 4'b1011;
        return v[2:0];
    endfunction

    // Monitor: pop on each new result, then verify it holds while valid.
    always @(negedge GCLK) begin
        if (RES_VALID && !prev_v) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                held = q.pop_front();
                chk("data_out", DATA_OUT, held.d);
                chk("res_error", RES_ERROR, held.e);
                chk("frame_cnt", FRAME_CNT, held.fc);
                chk("err_cnt", ERR_CNT, held.ec);
            end
        end else if (RES_VALID) begin
            chk("hold_data", DATA_OUT, held.d);
            chk("hold_err", RES_ERROR, held.e);
        end
        prev_v = RES_VALID;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge GCLK);
        #1;
    endtask

    // Drives START (unless chained), data MSB first, then the CRC bits.
    task automatic send_frame(input logic [7:0] d, input logic [2:0] c,
                              input bit b2b, input bit noise);
        exp_t e;
        if (!b2b) begin
            START = 1'b1;
            step();
        end
        for (int i = 7; i >= 0; i--) begin
            LINK_IN = d[i];
            START = noise ? 1'($urandom) : 1'b0;
            step();
        end
        for (int i = 2; i >= 0; i--) begin
            LINK_IN = c[i];
            START = noise ? 1'($urandom) : 1'b0;
            step();
        end
        START = 1'b0;
        e.d = d;
        e.e = (c != crc3(d));
        exp_frames = (exp_frames + 1) % 256;
        if (e.e && exp_errs < 255) exp_errs++;
        e.fc = 8'(exp_frames);
        e.ec = 8'(exp_errs);
        q.push_back(e);
    endtask

    task automatic ack(input bit s);
        int waited = 0;
        do begin
            step();
            waited++;
        end while (!RES_VALID && waited < 5);
        chk("result_latency", waited, 1);
        RES_ACK = 1'b1;
        START = s;
        step();
        RES_ACK = 1'b0;
        START = 1'b0;
        chk("ack_busy", BUSY, s);
        chk("ack_valid", RES_VALID, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_clr"}, CHK_CLR_bar, 0);
        chk({tag, "_sel"}, CHK_SELECT, 0);
        chk({tag, "_valid"}, RES_VALID, 0);
        chk({tag, "_err"}, RES_ERROR, 0);
        chk({tag, "_data"}, DATA_OUT, 0);
        chk({tag, "_fcnt"}, FRAME_CNT, 0);
        chk({tag, "_ecnt"}, ERR_CNT, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [2:0] c;
        bit         chain;
        CLEAR_bar = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        LINK_IN = 1'b0;
        RES_ACK = 1'b0;
        #3;
        check_reset_outputs("rst");
        step();
        step();
        CLEAR_bar = 1'b1;

        // Good frame A5 / 101, idle return on ack.
        send_frame(8'hA5, 3'b101, 1'b0, 1'b0);
        chk("pre_valid", RES_VALID, 0);
        chk("check_busy", BUSY, 1);
        ack(1'b0);
        // Corrupted CRC.
        send_frame(8'hA5, 3'b100, 1'b0, 1'b0);
        ack(1'b0);
        // Back-to-back: ack with START, then frame 00/000.
        send_frame(8'hA5, 3'b101, 1'b0, 1'b0);
        ack(1'b1);
        send_frame(8'h00, 3'b000, 1'b1, 1'b0);
        ack(1'b0);

        // Abort during CRC, with START asserted on the same edge.
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 9; i++) begin
            LINK_IN = 1'($urandom);
            step();
        end
        ABORT = 1'b1;
        START = 1'b1;
        step();
        ABORT = 1'b0;
        START = 1'b0;
        chk("abort_busy", BUSY, 0);
        chk("abort_clr", CHK_CLR_bar, 0);
        chk("abort_fcnt", FRAME_CNT, exp_frames);
        step();
        chk("abort_stay_idle", BUSY, 0);

        // START in RESULT without ack is ignored.
        send_frame(8'h3C, crc3(8'h3C), 1'b0, 1'b0);
        step();
        START = 1'b1;
        step();
        step();
        chk("start_no_ack_valid", RES_VALID, 1);
        chk("start_no_ack_busy", BUSY, 0);
        START = 1'b0;
        ack(1'b0);

        // Random frames, random chaining and START noise.
        chain = 1'b0;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            c = ($urandom_range(0, 1) == 0) ? crc3(d) : 3'($urandom);
            send_frame(d, c, chain, 1'b1);
            chain = 1'($urandom);
            ack(chain);
        end

        // Asynchronous reset in the middle of DATA.
        START = 1'b1;
        step();
        START = 1'b0;
        LINK_IN = 1'b1;
        step();
        step();
        #2;
        CLEAR_bar = 1'b0;
        #1;
        check_reset_outputs("async");
        exp_frames = 0;
        exp_errs = 0;
        step();
        CLEAR_bar = 1'b1;

        // 256 error frames: error counter saturates, frame counter wraps.
        for (int n = 0; n < 256; n++) begin
            d = 8'($urandom);
            c = crc3(d) ^ 3'($urandom_range(1, 7));
            send_frame(d, c, n > 0, 1'b0);
            ack(n < 255);
        end
        chk("sat_ecnt", ERR_CNT, exp_errs);
        chk("wrap_fcnt", FRAME_CNT, exp_frames);
        chk("sat_ecnt_255", ERR_CNT, 255);
        step();
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
